mempool_dma_split: RTL and testbench

- Sits directly downstream of the DMA frontend register file, which produces a `dma_req_t` (src, dst, num_bytes).
- Cuts each 1D DMA transfer into sub-requests that never cross a ChunkBytes-aligned boundary of the destination L1 address.
- Steers each sub-request to the group backend that owns that chunk.
- Counts outstanding sub-requests and reports transfer completion back to the frontend as `trans_complete` and `backend_idle` (the `dma_meta_t` fields).

---
 rtl/mempool_dma_split_if.sv | 30 +++
 rtl/mempool_dma_split.sv | 82 ++++++++
 tb/tb_mempool_dma_split.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mempool_dma_split_if.sv
// mempool_dma_split_if: request, sub-request and completion signals of the DMA split stage
interface mempool_dma_split_if #(
  parameter int AddrWidth  = 32,
  parameter int NumTargets = 4
);
  logic [AddrWidth-1:0]          req_src_i;
  logic [AddrWidth-1:0]          req_dst_i;
  logic [31:0]                   req_num_bytes_i;
  logic                          req_valid_i;
  logic                          req_ready_o;
  logic [AddrWidth-1:0]          sub_src_o;
  logic [AddrWidth-1:0]          sub_dst_o;
  logic [31:0]                   sub_num_bytes_o;
  logic [$clog2(NumTargets)-1:0] sub_target_o;
  logic                          sub_valid_o;
  logic                          sub_ready_i;
  logic [NumTargets-1:0]         sub_done_i;
  logic                          trans_complete_o;
  logic                          backend_idle_o;
  modport master (
    output req_src_i, req_dst_i, req_num_bytes_i, req_valid_i, sub_ready_i, sub_done_i,
    input  req_ready_o, sub_src_o, sub_dst_o, sub_num_bytes_o, sub_target_o, sub_valid_o,
           trans_complete_o, backend_idle_o
  );
  modport slave (
    input  req_src_i, req_dst_i, req_num_bytes_i, req_valid_i, sub_ready_i, sub_done_i,
    output req_ready_o, sub_src_o, sub_dst_o, sub_num_bytes_o, sub_target_o, sub_valid_o,
           trans_complete_o, backend_idle_o
  );
endinterface

// File: rtl/mempool_dma_split.sv
// mempool_dma_split: cuts 1D DMA transfers at destination chunk boundaries and tracks completion
module mempool_dma_split #(
  parameter int AddrWidth      = 32,
  parameter int ChunkBytes     = 4096,
  parameter int NumTargets     = 4,
  parameter int MaxOutstanding = 16
) (
  input logic                clk_i,
  input logic                rst_ni,
  mempool_dma_split_if.slave bus
);
  localparam int CW = $clog2(ChunkBytes);
  localparam int TW = $clog2(NumTargets);
  localparam int OW = $clog2(MaxOutstanding + 1);
  typedef enum logic [1:0] {S_IDLE, S_SPLIT, S_WAIT} state_e;
  state_e               r_state;
  logic [AddrWidth-1:0] r_src, r_dst;
  logic [31:0]          r_rem;
  logic [OW-1:0]        r_out;
  logic                 r_ready, r_cmpl, r_idle;
  logic [31:0]          w_room, w_len, w_sum, w_pop;
  logic [OW-1:0]        w_out_n;
  logic                 w_valid, w_issue;
  always_comb begin
    w_room  = 32'(ChunkBytes) - 32'(r_dst[CW-1:0]);
    w_len   = r_rem < w_room ? r_rem : w_room;
    w_valid = r_state == S_SPLIT && r_out < OW'(MaxOutstanding);
    w_issue = w_valid && bus.sub_ready_i;
    w_sum   = 32'(r_out) + 32'(w_issue);
    w_pop   = 32'($countones(bus.sub_done_i));
    // a done with nothing outstanding is illegal; clamp instead of wrapping
    w_out_n = w_sum < w_pop ? '0 : OW'(w_sum - w_pop);
  end
  assign bus.req_ready_o      = r_ready;
  assign bus.sub_src_o        = r_src;
  assign bus.sub_dst_o        = r_dst;
  assign bus.sub_num_bytes_o  = w_len;
  assign bus.sub_target_o     = r_dst[CW+:TW];
  assign bus.sub_valid_o      = w_valid;
  assign bus.trans_complete_o = r_cmpl;
  assign bus.backend_idle_o   = r_idle;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_out   <= '0;
      r_ready <= 1'b1;
      r_cmpl  <= 1'b0;
      r_idle  <= 1'b1;
    end else begin
      r_out  <= w_out_n;
      r_cmpl <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.req_valid_i) begin
          r_src   <= bus.req_src_i;
          r_dst   <= bus.req_dst_i;
          r_rem   <= bus.req_num_bytes_i;
          r_state <= bus.req_num_bytes_i != 32'd0 ? S_SPLIT : S_WAIT;
          r_ready <= 1'b0;
          r_idle  <= 1'b0;
        end
        S_SPLIT: if (w_issue) begin
          r_src <= r_src + AddrWidth'(w_len);
          r_dst <= r_dst + AddrWidth'(w_len);
          r_rem <= r_rem - w_len;
          if (r_rem == w_len) r_state <= S_WAIT;
        end
        S_WAIT: if (w_out_n == '0) begin
          r_state <= S_IDLE;
          r_cmpl  <= 1'b1;
          r_ready <= 1'b1;
          r_idle  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assert property (@(posedge clk_i) disable iff (!rst_ni) w_sum >= w_pop)
    else $error("sub_done_i pulse with no outstanding sub-request");
endmodule

// File: tb/tb_mempool_dma_split.sv
// tb_mempool_dma_split: directed and random transfers checked against a chunk-splitting reference model
module tb_mempool_dma_split;
  localparam int C = 4096, NT = 4, MAX = 4, BOUND = 3000;
  typedef struct {logic [31:0] s, d, l; int t;} sub_t;
  typedef enum {P_IDLE, P_SPLIT, P_WAIT} phase_e;
  logic clk = 1'b0, rst_ni = 1'b0;
  always #5 clk = ~clk;
  mempool_dma_split_if #(.AddrWidth(32), .NumTargets(NT)) bus ();
  mempool_dma_split #(.AddrWidth(32), .ChunkBytes(C), .NumTargets(NT), .MaxOutstanding(MAX)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus)
  );
  int ncmp = 0, nfail = 0, now = 0, m_out = 0, xfer_issued = 0, dut_issued = 0;
  int stall_n = 0, stall_idx = 0, rdy_mode = 0, d0 = 0;
  bit hold_done = 0, pend_req = 0, exp_cmpl = 0;
  logic [31:0] p_src = 0, p_dst = 0, p_n = 0;
  phase_e ph = P_IDLE;
  sub_t q[$];
  int due[$], tg[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected sub-requests: cut at every chunk boundary of the destination
  function automatic void plan(logic [31:0] s, logic [31:0] d, logic [31:0] n);
    logic [31:0] room, len;
    sub_t e;
    q.delete();
    while (n != 0) begin
      room = C - (d % C);
      len = n < room ? n : room;
      e.s = s; e.d = d; e.l = len; e.t = int'((d / C) % NT);
      q.push_back(e);
      s += len; d += len; n -= len;
    end
  endfunction

  task automatic start(logic [31:0] s, logic [31:0] d, logic [31:0] n);
    p_src = s; p_dst = d; p_n = n; pend_req = 1; d0 = dut_issued;
  endtask

  task automatic cycle();
    bit ev, rdy, hs;
    logic [NT-1:0] dn;
    int nd[$], nt[$];
    int pop;
    @(posedge clk); #1; now++;
    ev = ph == P_SPLIT && q.size() > 0 && m_out < MAX;
    chk("sub_valid", bus.sub_valid_o, ev);
    chk("req_ready", bus.req_ready_o, ph == P_IDLE);
    chk("backend_idle", bus.backend_idle_o, ph == P_IDLE && m_out == 0);
    chk("trans_complete", bus.trans_complete_o, exp_cmpl);
    if (ev) begin
      chk("sub_src", bus.sub_src_o, q[0].s);
      chk("sub_dst", bus.sub_dst_o, q[0].d);
      chk("sub_len", bus.sub_num_bytes_o, q[0].l);
      chk("sub_target", bus.sub_target_o, q[0].t);
    end
    rdy = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'b0 : $urandom_range(0, 3) != 0;
    if (stall_n > 0 && ev && xfer_issued == stall_idx) begin rdy = 0; stall_n--; end
    dn = '0;
    for (int i = 0; i < due.size(); i++)
      if (!hold_done && due[i] <= now && !dn[tg[i]]) dn[tg[i]] = 1'b1;
      else begin nd.push_back(due[i]); nt.push_back(tg[i]); end
    due = nd; tg = nt;
    bus.req_valid_i = pend_req; bus.req_src_i = p_src; bus.req_dst_i = p_dst;
    bus.req_num_bytes_i = p_n; bus.sub_ready_i = rdy; bus.sub_done_i = dn;
    if (bus.sub_valid_o === 1'b1 && rdy) dut_issued++;
    hs = ev && rdy;
    pop = $countones(dn);
    if (hs) begin
      due.push_back(now + int'($urandom_range(1, 6)));
      tg.push_back(q[0].t);
      void'(q.pop_front());
      xfer_issued++;
    end
    m_out += int'(hs) - pop;
    exp_cmpl = 0;
    case (ph)
      P_IDLE: if (pend_req) begin
        plan(p_src, p_dst, p_n);
        ph = p_n != 0 ? P_SPLIT : P_WAIT;
        pend_req = 0; xfer_issued = 0;
      end
      P_SPLIT: if (hs && q.size() == 0) ph = P_WAIT;
      P_WAIT: if (m_out == 0) begin exp_cmpl = 1; ph = P_IDLE; end
      default: ;
    endcase
  endtask

  task automatic finish_xfer(string tag);
    int k = 0;
    do begin cycle(); k++; end while ((pend_req || ph != P_IDLE || exp_cmpl) && k < BOUND);
    if (k >= BOUND) begin
      ncmp++; nfail++;
      $error("FAIL %s_timeout: observed no completion after %0d cycles, expected completion", tag, k);
    end
  endtask

  initial begin
    bus.req_valid_i = 0; bus.req_src_i = 0; bus.req_dst_i = 0; bus.req_num_bytes_i = 0;
    bus.sub_ready_i = 0; bus.sub_done_i = '0;
    #12;
    chk("rst_ready", bus.req_ready_o, 1);
    chk("rst_valid", bus.sub_valid_o, 0);
    chk("rst_cmpl", bus.trans_complete_o, 0);
    chk("rst_idle", bus.backend_idle_o, 1);
    chk("rst_src", bus.sub_src_o, 0);
    chk("rst_dst", bus.sub_dst_o, 0);
    chk("rst_len", bus.sub_num_bytes_o, 0);
    @(negedge clk) rst_ni = 1;
    rdy_mode = 1;
    start(32'h8000_0000, 32'h0, C);
    finish_xfer("aligned");
    chk("aligned_subs", dut_issued - d0, 1);
    rdy_mode = 0;
    start(32'h1000, 32'h0F00, 32'h2200);
    finish_xfer("unaligned");
    chk("unaligned_subs", dut_issued - d0, 4);
    rdy_mode = 1; stall_n = 5; stall_idx = 1;
    start(32'h2000_0000, 32'h5000_0800, 3 * C);
    finish_xfer("backpressure");
    chk("bp_subs", dut_issued - d0, 4);
    chk("bp_stall_used", stall_n, 0);
    hold_done = 1;
    start(32'h0, 32'h4_0000, (MAX + 2) * C);
    repeat (10) cycle();
    chk("credit_issued", dut_issued - d0, MAX);
    chk("credit_valid", bus.sub_valid_o, 0);
    hold_done = 0;
    finish_xfer("credit");
    chk("credit_subs", dut_issued - d0, MAX + 2);
    rdy_mode = 0;
    start(32'h1234, 32'h5678, 0);
    repeat (3) cycle();
    chk("zero_cmpl_at_2", bus.trans_complete_o, 1);
    finish_xfer("zero");
    chk("zero_subs", dut_issued - d0, 0);
    rdy_mode = 1; hold_done = 1;
    start(32'h100, 32'h1_0000, 4 * C);
    repeat (3) cycle();
    rdy_mode = 2;
    repeat (7) cycle();
    rdy_mode = 1; hold_done = 0;
    cycle();
    finish_xfer("simultaneous");
    chk("simul_subs", dut_issued - d0, 4);
    hold_done = 1;
    start(32'h0, 32'h100, 8 * C);
    repeat (4) cycle();
    #3 rst_ni = 0;
    #1;
    chk("arst_valid", bus.sub_valid_o, 0);
    chk("arst_ready", bus.req_ready_o, 1);
    chk("arst_idle", bus.backend_idle_o, 1);
    chk("arst_cmpl", bus.trans_complete_o, 0);
    chk("arst_len", bus.sub_num_bytes_o, 0);
    bus.req_valid_i = 0; bus.sub_ready_i = 0; bus.sub_done_i = '0;
    ph = P_IDLE; m_out = 0; q.delete(); due.delete(); tg.delete();
    exp_cmpl = 0; pend_req = 0; hold_done = 0;
    #10 rst_ni = 1;
    start(32'hABC0, 32'hFFF0, 2 * C);
    finish_xfer("after_reset");
    chk("after_reset_subs", dut_issued - d0, 3);
    rdy_mode = 0;
    repeat (25) begin
      logic [31:0] d, n;
      d = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF - $urandom_range(0, 2 * C) : $urandom;
      n = $urandom_range(0, 5) == 0 ? 32'd0 : $urandom_range(1, 5 * C);
      start($urandom, d, n);
      finish_xfer("random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
